// File: rtl/fnd_scan_decoder.sv
// Receive-side monitor for the multiplexed 4-digit FND bus: filters scan glitches and rebuilds a 16-bit BCD frame.
// Optional decimal-point capture is enabled by defining FND_DP_CAPTURE_EN.
module fnd_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_FND_Digit,
  input  logic [7:0]  i_FND_Font,
  output logic [15:0] o_value,
  output logic        o_frame_valid,
  output logic        o_frame_err,
  output logic [3:0]  o_dp,
  output logic        o_stale
);

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  SETTLE_PRE   = 8'(SETTLE_CYCLES - 2);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [3:0]  sample_digit;
  logic [7:0]  sample_font;
  logic [3:0]  prev_digit;
  logic [7:0]  prev_font;
  logic [7:0]  stable_cnt;
  logic [15:0] shadow;
  logic [3:0]  mask;
  logic        err_acc;
  logic [31:0] timer;

  logic        sel_valid;
  logic [1:0]  sel_pos;
  logic [3:0]  sel_onehot;
  logic [3:0]  nibble;
  logic        bad_font;
  logic        pair_same;
  logic        capture;
  logic        timeout_hit;
  logic [15:0] shadow_merged;
  logic [3:0]  mask_merged;

  // Exactly one active-low select bit identifies a scan position; anything else is a blank or overlap.
  always_comb begin
    sel_valid  = 1'b1;
    sel_pos    = 2'd0;
    sel_onehot = 4'b0000;
    case (sample_digit)
      4'b1110: begin sel_pos = 2'd0; sel_onehot = 4'b0001; end
      4'b1101: begin sel_pos = 2'd1; sel_onehot = 4'b0010; end
      4'b1011: begin sel_pos = 2'd2; sel_onehot = 4'b0100; end
      4'b0111: begin sel_pos = 2'd3; sel_onehot = 4'b1000; end
      default: sel_valid = 1'b0;
    endcase
  end

  always_comb begin
    bad_font = 1'b0;
    nibble   = 4'hF;
    case (sample_font[6:0])
      7'h40:   nibble = 4'd0;
      7'h79:   nibble = 4'd1;
      7'h24:   nibble = 4'd2;
      7'h30:   nibble = 4'd3;
      7'h19:   nibble = 4'd4;
      7'h12:   nibble = 4'd5;
      7'h02:   nibble = 4'd6;
      7'h78:   nibble = 4'd7;
      7'h00:   nibble = 4'd8;
      7'h10:   nibble = 4'd9;
      default: bad_font = 1'b1;
    endcase
  end

  // Position 0 lives in the most significant nibble of the frame.
  always_comb begin
    shadow_merged = shadow;
    case (sel_pos)
      2'd0:    shadow_merged[15:12] = nibble;
      2'd1:    shadow_merged[11:8]  = nibble;
      2'd2:    shadow_merged[7:4]   = nibble;
      default: shadow_merged[3:0]   = nibble;
    endcase
  end

  assign mask_merged = mask | sel_onehot;
  assign pair_same   = (sample_digit == prev_digit) && (sample_font == prev_font);
  assign capture     = sel_valid && pair_same && (stable_cnt == SETTLE_PRE);
  assign timeout_hit = (timer == TIMEOUT_LAST);

  // Counter saturates at SETTLE_LAST so a held pair is captured only once.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sample_digit  <= 4'b0000;
      sample_font   <= 8'h00;
      prev_digit    <= 4'b0000;
      prev_font     <= 8'h00;
      stable_cnt    <= 8'd0;
      shadow        <= 16'h0000;
      mask          <= 4'b0000;
      err_acc       <= 1'b0;
      timer         <= 32'd0;
      o_value       <= 16'h0000;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      o_stale       <= 1'b0;
    end else begin
      sample_digit  <= i_FND_Digit;
      sample_font   <= i_FND_Font;
      prev_digit    <= sample_digit;
      prev_font     <= sample_font;
      o_frame_valid <= 1'b0;

      if (!sel_valid || !pair_same)
        stable_cnt <= 8'd0;
      else if (stable_cnt != SETTLE_LAST)
        stable_cnt <= stable_cnt + 8'd1;

      // A capture takes priority over a coinciding timeout.
      if (capture) begin
        shadow  <= shadow_merged;
        timer   <= 32'd0;
        o_stale <= 1'b0;
        if (mask_merged == 4'b1111) begin
          o_value       <= shadow_merged;
          o_frame_err   <= err_acc | bad_font;
          o_frame_valid <= 1'b1;
          mask          <= 4'b0000;
          err_acc       <= 1'b0;
        end else begin
          mask    <= mask_merged;
          err_acc <= err_acc | bad_font;
        end
      end else if (timeout_hit) begin
        o_stale <= 1'b1;
        mask    <= 4'b0000;
        err_acc <= 1'b0;
      end else begin
        timer <= timer + 32'd1;
      end
    end
  end

`ifdef FND_DP_CAPTURE_EN
  logic [3:0] shadow_dp;
  logic [3:0] dp_merged;

  // Decimal point is active-low on font bit 7; stored active-high per position.
  always_comb begin
    dp_merged          = shadow_dp;
    dp_merged[sel_pos] = ~sample_font[7];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shadow_dp <= 4'b0000;
      o_dp      <= 4'b0000;
    end else if (capture) begin
      shadow_dp <= dp_merged;
      if (mask_merged == 4'b1111)
        o_dp <= dp_merged;
    end
  end
`else
  assign o_dp = 4'b0000;
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed self-checking bench for fnd_scan_decoder (SETTLE_CYCLES=4, TIMEOUT_CYCLES=50).
// Expected o_dp follows FND_DP_CAPTURE_EN.
module tb_fnd_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  digit;
  logic [7:0]  font;
  logic [15:0] o_value;
  logic        o_frame_valid;
  logic        o_frame_err;
  logic [3:0]  o_dp;
  logic        o_stale;

  int checks = 0;
  int passes = 0;

`ifdef FND_DP_CAPTURE_EN
  localparam logic [3:0] DP_EXP = 4'b1010;
`else
  localparam logic [3:0] DP_EXP = 4'b0000;
`endif

  always #5 clk = ~clk;

  fnd_scan_decoder #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_FND_Digit  (digit),
    .i_FND_Font   (font),
    .o_value      (o_value),
    .o_frame_valid(o_frame_valid),
    .o_frame_err  (o_frame_err),
    .o_dp         (o_dp),
    .o_stale      (o_stale)
  );

  // Holds one digit/font pair for n cycles and records any frame pulse seen.
  task automatic applyStimulus(input logic [3:0] d, input logic [7:0] f, input int n,
                               output int pulses, output int first_idx,
                               output logic [15:0] val, output logic err, output logic [3:0] dp);
    digit = d;
    font  = f;
    pulses = 0;
    first_idx = -1;
    val = 16'h0000;
    err = 1'b0;
    dp  = 4'b0000;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (o_frame_valid) begin
        pulses++;
        if (first_idx < 0) begin
          first_idx = i;
          val = o_value;
          err = o_frame_err;
          dp  = o_dp;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    digit = 4'hF;
    font  = 8'hFF;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scans four positions (10 cycles each); reports pulses and pulse data.
  task automatic scan_frame(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2,
                            input logic [7:0] f3, output int total, output int idx3,
                            output logic [15:0] val, output logic err, output logic [3:0] dp);
    int p, idx;
    logic [15:0] v;
    logic e;
    logic [3:0] d;
    total = 0;
    applyStimulus(4'b1110, f0, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1101, f1, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1011, f2, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b0111, f3, 10, p, idx3, val, err, dp); total += p;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_value !== 16'h0000) $display("[TB] FAIL reset_value: got %h expected %h", o_value, 16'h0000); else passes++;
    checks++; if (o_frame_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", o_frame_valid); else passes++;
    checks++; if (o_frame_err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", o_frame_err); else passes++;
    checks++; if (o_dp !== 4'b0000) $display("[TB] FAIL reset_dp: got %b expected 0000", o_dp); else passes++;
    checks++; if (o_stale !== 1'b0) $display("[TB] FAIL reset_stale: got %b expected 0", o_stale); else passes++;
  endtask

  task automatic test_full_frame();
    int total, idx3;
    logic [15:0] v;
    logic e;
    logic [3:0] d;
    do_reset();
    scan_frame(8'hC0, 8'hA4, 8'h99, 8'hF8, total, idx3, v, e, d);
    checks++; if (total !== 1) $display("[TB] FAIL full_pulses: got %0d expected 1", total); else passes++;
    checks++; if (idx3 !== 4) $display("[TB] FAIL full_latency: got edge %0d expected 4", idx3); else passes++;
    checks++; if (v !== 16'h0247) $display("[TB] FAIL full_value: got %h expected %h", v, 16'h0247); else passes++;
    checks++; if (e !== 1'b0) $display("[TB] FAIL full_err: got %b expected 0", e); else passes++;
    checks++; if (d !== 4'b0000) $display("[TB] FAIL full_dp: got %b expected 0000", d); else passes++;
    checks++; if (o_value !== 16'h0247) $display("[TB] FAIL full_hold: got %h expected %h", o_value, 16'h0247); else passes++;
  endtask

  task automatic test_glitch();
    int p, idx, total;
    logic [15:0] v;
    logic e;
    logic [3:0] d;
    do_reset();
    total = 0;
    applyStimulus(4'b1110, 8'hC0, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1101, 8'hA4, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1011, 8'h99, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b0111, 8'hF8, 3, p, idx, v, e, d); total += p;
    checks++; if (total !== 0) $display("[TB] FAIL glitch_short_hold: got %0d pulses expected 0", total); else passes++;
    applyStimulus(4'b0111, 8'h80, 10, p, idx, v, e, d);
    checks++; if (p !== 1) $display("[TB] FAIL glitch_pulses: got %0d expected 1", p); else passes++;
    checks++; if (v !== 16'h0248) $display("[TB] FAIL glitch_value: got %h expected %h", v, 16'h0248); else passes++;

    do_reset();
    total = 0;
    applyStimulus(4'b1110, 8'hC0, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1101, 8'hA4, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1011, 8'h99, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1111, 8'hF8, 16, p, idx, v, e, d); total += p;
    applyStimulus(4'b1100, 8'hF8, 16, p, idx, v, e, d); total += p;
    checks++; if (total !== 0) $display("[TB] FAIL invalid_select: got %0d pulses expected 0", total); else passes++;
    applyStimulus(4'b0111, 8'hF8, 10, p, idx, v, e, d);
    checks++; if (p !== 1) $display("[TB] FAIL mask_kept_pulses: got %0d expected 1", p); else passes++;
    checks++; if (v !== 16'h0247) $display("[TB] FAIL mask_kept_value: got %h expected %h", v, 16'h0247); else passes++;
  endtask

  task automatic test_bad_font();
    int total, idx3;
    logic [15:0] v;
    logic e;
    logic [3:0] d;
    do_reset();
    scan_frame(8'hC0, 8'hA4, 8'hFF, 8'hF8, total, idx3, v, e, d);
    checks++; if (total !== 1) $display("[TB] FAIL bad_pulses: got %0d expected 1", total); else passes++;
    checks++; if (v !== 16'h02F7) $display("[TB] FAIL bad_value: got %h expected %h", v, 16'h02F7); else passes++;
    checks++; if (e !== 1'b1) $display("[TB] FAIL bad_err: got %b expected 1", e); else passes++;
    scan_frame(8'hF9, 8'hB0, 8'h92, 8'h82, total, idx3, v, e, d);
    checks++; if (v !== 16'h1356) $display("[TB] FAIL next_value: got %h expected %h", v, 16'h1356); else passes++;
    checks++; if (e !== 1'b0) $display("[TB] FAIL next_err_cleared: got %b expected 0", e); else passes++;
  endtask

  task automatic test_duplicate_reset();
    int p, idx, total;
    logic [15:0] v, vlast;
    logic e;
    logic [3:0] d;
    do_reset();
    total = 0;
    applyStimulus(4'b1110, 8'hC0, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1101, 8'hA4, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1110, 8'hF9, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1011, 8'h99, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b0111, 8'hF8, 10, p, idx, vlast, e, d); total += p;
    checks++; if (total !== 1) $display("[TB] FAIL dup_pulses: got %0d expected 1", total); else passes++;
    checks++; if (vlast !== 16'h1247) $display("[TB] FAIL dup_value: got %h expected %h", vlast, 16'h1247); else passes++;

    applyStimulus(4'b1110, 8'hC0, 10, p, idx, v, e, d);
    applyStimulus(4'b1101, 8'hA4, 10, p, idx, v, e, d);
    applyStimulus(4'b1110, 8'hF9, 10, p, idx, v, e, d);
    do_reset();
    checks++; if (o_value !== 16'h0000) $display("[TB] FAIL midreset_value: got %h expected %h", o_value, 16'h0000); else passes++;
    checks++; if ({o_frame_valid, o_frame_err, o_stale, o_dp} !== 7'd0) $display("[TB] FAIL midreset_flags: got %b expected 0000000", {o_frame_valid, o_frame_err, o_stale, o_dp}); else passes++;
    total = 0;
    applyStimulus(4'b1011, 8'h99, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b0111, 8'hF8, 10, p, idx, v, e, d); total += p;
    checks++; if (total !== 0) $display("[TB] FAIL midreset_partial: got %0d pulses expected 0", total); else passes++;
    applyStimulus(4'b1110, 8'h90, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b1101, 8'h80, 10, p, idx, vlast, e, d); total += p;
    checks++; if (total !== 1) $display("[TB] FAIL postreset_pulses: got %0d expected 1", total); else passes++;
    checks++; if (vlast !== 16'h9847) $display("[TB] FAIL postreset_value: got %h expected %h", vlast, 16'h9847); else passes++;
  endtask

  task automatic test_stale();
    int p, idx, total, first_stale, first_clear;
    logic [15:0] v;
    logic e;
    logic [3:0] d;
    do_reset();
    applyStimulus(4'b1110, 8'hC0, 10, p, idx, v, e, d);
    applyStimulus(4'b1101, 8'hA4, 5, p, idx, v, e, d);
    checks++; if (o_stale !== 1'b0) $display("[TB] FAIL stale_early: got %b expected 0", o_stale); else passes++;
    digit = 4'hF;
    font  = 8'hFF;
    first_stale = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (o_stale && first_stale < 0) first_stale = i;
    end
    checks++; if (first_stale !== 50) $display("[TB] FAIL stale_cycle: got %0d expected 50", first_stale); else passes++;
    checks++; if (o_value !== 16'h0000) $display("[TB] FAIL stale_value_held: got %h expected %h", o_value, 16'h0000); else passes++;

    digit = 4'b1110;
    font  = 8'hF9;
    first_clear = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!o_stale && first_clear < 0) first_clear = i;
    end
    checks++; if (first_clear !== 4) $display("[TB] FAIL stale_clear: got edge %0d expected 4", first_clear); else passes++;
    total = 0;
    applyStimulus(4'b1011, 8'h92, 10, p, idx, v, e, d); total += p;
    applyStimulus(4'b0111, 8'h82, 10, p, idx, v, e, d); total += p;
    checks++; if (total !== 0) $display("[TB] FAIL stale_mask_cleared: got %0d pulses expected 0", total); else passes++;
    applyStimulus(4'b1101, 8'hB0, 10, p, idx, v, e, d);
    checks++; if (p !== 1) $display("[TB] FAIL stale_frame_pulses: got %0d expected 1", p); else passes++;
    checks++; if (v !== 16'h1356) $display("[TB] FAIL stale_frame_value: got %h expected %h", v, 16'h1356); else passes++;
  endtask

  task automatic test_dp();
    int total, idx3;
    logic [15:0] v;
    logic e;
    logic [3:0] d;
    do_reset();
    scan_frame(8'hC0, 8'h24, 8'h99, 8'h78, total, idx3, v, e, d);
    checks++; if (v !== 16'h0247) $display("[TB] FAIL dp_value: got %h expected %h", v, 16'h0247); else passes++;
    checks++; if (e !== 1'b0) $display("[TB] FAIL dp_err: got %b expected 0", e); else passes++;
    checks++; if (d !== DP_EXP) $display("[TB] FAIL dp_bits: got %b expected %b", d, DP_EXP); else passes++;
    checks++; if (o_dp !== DP_EXP) $display("[TB] FAIL dp_hold: got %b expected %b", o_dp, DP_EXP); else passes++;
  endtask

  initial begin
    reset = 1'b0;
    digit = 4'hF;
    font  = 8'hFF;
    test_reset();
    test_full_frame();
    test_glitch();
    test_bad_font();
    test_duplicate_reset();
    test_stale();
    test_dp();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
